// File: rtl/entrada_jogada.sv
// entrada_jogada: button front-end for the memory game.
// Synchronises the four raw buttons, debounces them, and accepts at most one
// one-hot play per press/release cycle. The accepted play is held on a
// registered bus and announced with a one-cycle strobe; non-one-hot patterns
// raise a separate one-cycle strobe instead.
module entrada_jogada #(
  parameter int DEBOUNCE_CYCLES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  input  logic       limpa,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       jogada_invalida,
  output logic [1:0] db_estado,
  output logic [3:0] db_botoes
);

  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    FILTRANDO     = 2'b01,
    REGISTRA      = 2'b10,
    ESPERA_SOLTAR = 2'b11
  } estado_t;

  // Last count value before a stable pattern is accepted or a release is seen.
  localparam logic [7:0] CNT_ULTIMO = 8'(DEBOUNCE_CYCLES - 1);
  // Saturation value of the counter.
  localparam logic [7:0] CNT_CHEIO  = 8'(DEBOUNCE_CYCLES);

  // True when exactly one bit of the pattern is set.
  function automatic logic eh_um_quente(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic [3:0] cand_r;
  logic [3:0] cand_s;
  estado_t    estado_r;
  estado_t    estado_s;
  logic [3:0] jogada_r;
  logic [3:0] jogada_s;
  logic       tem_jogada_r;
  logic       tem_jogada_s;
  logic       invalida_r;
  logic       invalida_s;

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= botoes;
      sync2_r <= sync1_r;
    end
  end

  // State register of the debounce FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Datapath and output registers: counter, candidate, play bus and strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r        <= 8'd0;
      cand_r       <= 4'b0000;
      jogada_r     <= 4'b0000;
      tem_jogada_r <= 1'b0;
      invalida_r   <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      cand_r       <= cand_s;
      jogada_r     <= jogada_s;
      tem_jogada_r <= tem_jogada_s;
      invalida_r   <= invalida_s;
    end
  end

  // Next-state and next-datapath logic; habilita only matters on the edge
  // that enters REGISTRA, so the strobes are computed on that edge and
  // registered, making them visible during the REGISTRA cycle.
  always_comb begin
    estado_s     = estado_r;
    cnt_s        = cnt_r;
    cand_s       = cand_r;
    jogada_s     = jogada_r;
    tem_jogada_s = 1'b0;
    invalida_s   = 1'b0;

    case (estado_r)
      OCIOSO: begin
        if (sync2_r != 4'b0000) begin
          estado_s = FILTRANDO;
          cand_s   = sync2_r;
          cnt_s    = 8'd1;
        end else begin
          estado_s = OCIOSO;
        end
      end

      FILTRANDO: begin
        if (sync2_r == 4'b0000) begin
          // Too short: treated as a glitch, no output.
          estado_s = OCIOSO;
        end else if (sync2_r != cand_r) begin
          // Pattern changed while filtering: restart on the new pattern.
          cand_s = sync2_r;
          cnt_s  = 8'd1;
        end else if (cnt_r == CNT_ULTIMO) begin
          estado_s = REGISTRA;
          if (habilita && eh_um_quente(cand_r)) begin
            jogada_s     = cand_r;
            tem_jogada_s = 1'b1;
          end else if (habilita) begin
            invalida_s = 1'b1;
          end else begin
            tem_jogada_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      REGISTRA: begin
        estado_s = ESPERA_SOLTAR;
        cnt_s    = 8'd0;
      end

      ESPERA_SOLTAR: begin
        if (sync2_r != 4'b0000) begin
          // Still held (or pressed again): restart the release filter.
          cnt_s = 8'd0;
        end else if (cnt_r == CNT_ULTIMO) begin
          cnt_s    = CNT_CHEIO;
          estado_s = OCIOSO;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end

      default: begin
        estado_s = OCIOSO;
        cnt_s    = 8'd0;
        cand_s   = 4'b0000;
      end
    endcase

    // Clear wins over a simultaneous load; the strobe is left untouched.
    if (limpa) begin
      jogada_s = 4'b0000;
    end else begin
      jogada_s = jogada_s;
    end
  end

  assign jogada          = jogada_r;
  assign tem_jogada      = tem_jogada_r;
  assign jogada_invalida = invalida_r;
  assign db_estado       = estado_r;
  assign db_botoes       = sync2_r;

endmodule

// File: tb/tb_entrada_jogada.sv
// Self-checking bench for entrada_jogada: directed scenarios plus random
// button traffic, compared every cycle against a run-length reference model.
module tb_entrada_jogada;

  localparam int D = 5;

  logic       clock;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic       limpa;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic [1:0] db_estado;
  logic [3:0] db_botoes;

  int n_checks;
  int n_pass;
  int n_tem;
  int n_inv;

  // Reference model state (abstract: input delay line, run lengths, lock flag).
  logic [3:0] m_q[$];
  logic [3:0] m_val;
  int         m_run;
  int         m_zrun;
  bit         m_locked;
  bit         m_skip;
  logic [3:0] m_jog;
  logic       m_tem;
  logic       m_inv;
  logic [1:0] m_est;

  entrada_jogada #(.DEBOUNCE_CYCLES(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .botoes         (botoes),
    .habilita       (habilita),
    .limpa          (limpa),
    .jogada         (jogada),
    .tem_jogada     (tem_jogada),
    .jogada_invalida(jogada_invalida),
    .db_estado      (db_estado),
    .db_botoes      (db_botoes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = {4'b0000, 4'b0000};
    m_val = 4'b0000;
    m_run = 0;
    m_zrun = 0;
    m_locked = 0;
    m_skip = 0;
    m_jog = 4'b0000;
    m_tem = 1'b0;
    m_inv = 1'b0;
    m_est = 2'd0;
  endtask

  // One clock edge of the reference model, using inputs stable before the edge.
  task automatic model_step(input logic [3:0] b, input logic h, input logic l);
    logic [3:0] seen;
    bit fired;
    seen = m_q[0];
    fired = 0;
    m_tem = 1'b0;
    m_inv = 1'b0;
    if (!m_locked) begin
      if (seen == 4'b0000) begin
        m_run = 0;
      end else if (m_run != 0 && seen == m_val) begin
        m_run++;
      end else begin
        m_val = seen;
        m_run = 1;
      end
      if (m_run == D) begin
        fired = 1;
        m_locked = 1;
        m_skip = 1;
        m_zrun = 0;
        m_run = 0;
        if (h && $countones(m_val) == 1) begin
          m_tem = 1'b1;
          m_jog = m_val;
        end else if (h) begin
          m_inv = 1'b1;
        end
      end
    end else if (m_skip) begin
      m_skip = 0;
      m_zrun = 0;
    end else begin
      if (seen != 4'b0000) m_zrun = 0;
      else m_zrun++;
      if (m_zrun == D) begin
        m_locked = 0;
        m_run = 0;
      end
    end
    if (l) m_jog = 4'b0000;
    void'(m_q.pop_front());
    m_q.push_back(b);
    if (fired) m_est = 2'd2;
    else if (m_locked) m_est = 2'd3;
    else if (m_run != 0) m_est = 2'd1;
    else m_est = 2'd0;
  endtask

  task automatic ciclo(input logic [3:0] b, input logic h, input logic l);
    botoes = b;
    habilita = h;
    limpa = l;
    @(posedge clock);
    model_step(b, h, l);
    @(negedge clock);
    check_eq("jogada", {4'b0000, jogada}, {4'b0000, m_jog});
    check_eq("tem_jogada", {7'b0, tem_jogada}, {7'b0, m_tem});
    check_eq("jogada_invalida", {7'b0, jogada_invalida}, {7'b0, m_inv});
    check_eq("db_estado", {6'b0, db_estado}, {6'b0, m_est});
    check_eq("db_botoes", {4'b0000, db_botoes}, {4'b0000, m_q[0]});
    if (tem_jogada) n_tem++;
    if (jogada_invalida) n_inv++;
  endtask

  task automatic hold(input logic [3:0] b, input int n, input logic h);
    for (int i = 0; i < n; i++) ciclo(b, h, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_jogada"}, {4'b0000, jogada}, 8'h00);
    check_eq({tag, "_tem"}, {7'b0, tem_jogada}, 8'h00);
    check_eq({tag, "_inv"}, {7'b0, jogada_invalida}, 8'h00);
    check_eq({tag, "_estado"}, {6'b0, db_estado}, 8'h00);
    check_eq({tag, "_botoes"}, {4'b0000, db_botoes}, 8'h00);
  endtask

  initial begin
    logic [3:0] pat;
    int len;
    logic h;
    n_checks = 0;
    n_pass = 0;
    n_tem = 0;
    n_inv = 0;
    reset = 1'b0;
    botoes = 4'b0000;
    habilita = 1'b1;
    limpa = 1'b0;
    model_reset();
    @(negedge clock);
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    // Valid press 0001 held 10 clocks.
    n_tem = 0;
    hold(4'b0001, 10, 1'b1);
    hold(4'b0000, 15, 1'b1);
    check_eq("s1_tem_count", 8'(n_tem), 8'd1);
    check_eq("s1_jogada", {4'b0000, jogada}, 8'h01);

    // Short 3-clock pulse is discarded.
    n_tem = 0;
    hold(4'b0010, 3, 1'b1);
    hold(4'b0000, 10, 1'b1);
    check_eq("s2_tem_count", 8'(n_tem), 8'd0);
    check_eq("s2_jogada", {4'b0000, jogada}, 8'h01);

    // Bouncing 0100 then stable.
    n_tem = 0;
    hold(4'b0100, 1, 1'b1);
    hold(4'b0000, 1, 1'b1);
    hold(4'b0100, 1, 1'b1);
    hold(4'b0000, 1, 1'b1);
    hold(4'b0100, 10, 1'b1);
    hold(4'b0000, 15, 1'b1);
    check_eq("s3_tem_count", 8'(n_tem), 8'd1);
    check_eq("s3_jogada", {4'b0000, jogada}, 8'h04);

    // Multi-button press, enabled then disabled.
    n_tem = 0;
    n_inv = 0;
    hold(4'b0011, 10, 1'b1);
    hold(4'b0000, 15, 1'b1);
    check_eq("s4_inv_count", 8'(n_inv), 8'd1);
    check_eq("s4_tem_count", 8'(n_tem), 8'd0);
    check_eq("s4_jogada", {4'b0000, jogada}, 8'h04);
    n_inv = 0;
    hold(4'b0011, 10, 1'b0);
    hold(4'b0000, 15, 1'b0);
    check_eq("s4b_inv_count", 8'(n_inv), 8'd0);
    check_eq("s4b_tem_count", 8'(n_tem), 8'd0);

    // Long hold, then clear.
    n_tem = 0;
    hold(4'b1000, 40, 1'b1);
    check_eq("s5_estado_held", {6'b0, db_estado}, 8'h03);
    hold(4'b0000, 15, 1'b1);
    check_eq("s5_tem_count", 8'(n_tem), 8'd1);
    check_eq("s5_jogada", {4'b0000, jogada}, 8'h08);
    ciclo(4'b0000, 1'b1, 1'b1);
    check_eq("s5_limpa", {4'b0000, jogada}, 8'h00);
    hold(4'b0000, 3, 1'b1);

    // Asynchronous reset in the middle of filtering a held press.
    hold(4'b0001, 4, 1'b1);
    check_eq("s6_filtrando", {6'b0, db_estado}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("s6_async");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    n_tem = 0;
    hold(4'b0001, 10, 1'b1);
    hold(4'b0000, 15, 1'b1);
    check_eq("s6_tem_count", 8'(n_tem), 8'd1);
    check_eq("s6_jogada", {4'b0000, jogada}, 8'h01);

    // Random traffic against the model.
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 3))
        0: pat = 4'b0000;
        1: pat = 4'($urandom_range(1, 15));
        default: begin
          len = $urandom_range(0, 3);
          pat = 4'b0001 << len;
        end
      endcase
      len = $urandom_range(1, 14);
      h = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < len; i++) begin
        ciclo(pat, h, ($urandom_range(0, 19) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/entrada_jogada.md
# entrada_jogada

Button front-end for the memory game datapath; sits directly upstream of the play register and comparator in `circuito_exp5`. It synchronises and debounces the four raw `botoes` inputs and accepts exactly one valid one-hot press per press/release cycle. It presents the accepted play on a registered bus with a one-cycle `tem_jogada` strobe, which the control unit consumes. Multi-button presses and presses while disabled never reach the game.

## Interface
- `DEBOUNCE_CYCLES`, default 5: consecutive stable samples required to accept a press or a release. Legal range 2..255; 5 ms at 1 kHz.
- `clock`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock; reset is asynchronous and active-low.
- `botoes`  in  4  raw push-buttons, asynchronous, 1 = pressed.
- `habilita`  in  1  from control unit; 1 = plays are accepted.
- `limpa`  in  1  synchronous clear of `jogada`.
- `jogada`  out  4  last accepted play, one-hot, registered.
- `tem_jogada`  out  1  one-cycle strobe: new valid play loaded into `jogada`.
- `jogada_invalida`  out  1  one-cycle strobe: debounced pattern was not one-hot, with `habilita`=1.
- `db_estado`  out  2  FSM state code.
- `db_botoes`  out  4  synchronised button vector (`sync2`).

## Operation
- Synchroniser: two flip-flops per bit, `sync1` <- `botoes`, `sync2` <- `sync1`. The FSM and `db_botoes` use only `sync2`.
- Counter `cnt`: 8 bits, saturates at `DEBOUNCE_CYCLES`. Register `cand[3:0]` holds the candidate pattern.
- FSM states: OCIOSO=00, FILTRANDO=01, REGISTRA=10, ESPERA_SOLTAR=11.
- OCIOSO:
  - `sync2`≠0 -> FILTRANDO, with `cand`<=`sync2` and `cnt`<=1.
  - Otherwise stay.
- FILTRANDO:
  - `sync2`=0 -> OCIOSO. This is a glitch and produces no output.
  - `sync2`≠`cand` and `sync2`≠0 -> stay, with `cand`<=`sync2` and `cnt`<=1.
  - `sync2`=`cand` and `cnt`=`DEBOUNCE_CYCLES`-1 -> REGISTRA. On this same edge, `jogada`<=`cand` only if `cand` is one-hot and `habilita`=1.
  - `sync2`=`cand` otherwise -> `cnt`+1.
- REGISTRA lasts exactly one cycle, then goes unconditionally to ESPERA_SOLTAR with `cnt`<=0.
  - `tem_jogada`=1 if the load occurred.
  - `jogada_invalida`=1 if `cand` is not one-hot and `habilita`=1.
  - With `habilita`=0, neither strobe fires.
- ESPERA_SOLTAR:
  - `sync2`≠0 -> `cnt`<=0. Holding the buttons keeps the block here indefinitely.
  - `sync2`=0 -> `cnt`+1.
  - `cnt` reaching `DEBOUNCE_CYCLES` -> OCIOSO.
  - New presses are ignored in this state; no auto-repeat.
- `habilita` is sampled only on the edge entering REGISTRA. Changes at any other time have no effect on an in-progress press.
- `limpa`=1: `jogada`<=0 on the next edge in any state. `limpa` has priority over a simultaneous load; the `tem_jogada` strobe still fires in that case.
- One-hot test: exactly one bit set. 0000 never reaches REGISTRA.

## Timing
- Reset (`reset`=0) acts immediately. All outputs, `sync1`, `sync2`, `cand` and `cnt` go to 0, and the state goes to OCIOSO.
  - Reset asserted mid-press: after release of reset, a still-held button is re-filtered from scratch.
  - That re-filtered press is accepted if valid.
- Press latency: `botoes` stable before edge E0 -> `sync2` valid after E1 -> FILTRANDO entered at E2 -> REGISTRA entered at E(DEBOUNCE_CYCLES+1).
  - `tem_jogada` and the new `jogada` are visible for the cycle after that edge.
  - Default: strobe high between E6 and E7.
- Release latency: from the first `sync2`=0 sample in ESPERA_SOLTAR, `DEBOUNCE_CYCLES` edges until OCIOSO.
- Minimum accepted press is `DEBOUNCE_CYCLES` clocks; shorter pulses are discarded.
- Minimum press-to-press spacing is 2·`DEBOUNCE_CYCLES`+3 clocks. Presses arriving earlier are merged into the previous hold.
- Strobes are never high on two consecutive cycles.

## Test plan
- Reset, then `botoes`=0001 held 10 clocks with `habilita`=1 -> single `tem_jogada` pulse 6 edges after the input change, `jogada`=0001, `db_estado` sequence 00,01,10,11,00.
- 3-clock pulse 0010 -> no strobe, `jogada` unchanged, FSM returns to 00.
- 0100 bouncing (0100/0000/0100 alternating each clock for 4 clocks), then stable 10 clocks -> exactly one `tem_jogada`, `jogada`=0100.
- 0011 held 10 clocks -> one `jogada_invalida` pulse, no `tem_jogada`, `jogada` keeps its prior value; repeat with `habilita`=0 -> no strobes at all.
- 1000 held 40 clocks -> exactly one strobe, FSM remains 11 until 5 clocks after release; `limpa` pulse then -> `jogada`=0000.
- `reset`=0 asserted asynchronously mid-FILTRANDO with 0001 held -> outputs 0 immediately; after release, one `tem_jogada` 6 edges later.
